// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one outstanding IMEM request, feeds decode via IF reg + 1-entry skid.
// Latency: REQ at cycle c with immediate GNT and RVALID at c+1 gives IF_VALID at c+2 (1 instr / 2 cycles).
// Backpressure: STALL holds IF outputs; a word arriving under STALL parks in the skid and blocks new requests.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  input  logic        TRAP,
  input  logic [31:0] MTVEC,
  input  logic        MRET,
  input  logic [31:0] MEPC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        IF_VALID,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC,
  output logic        FLUSH_IF
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RST_PC     = RESET_VECTOR & ALIGN_MASK;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // One fetched word together with the address it came from.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_ent_t;

  state_t      state;
  logic [31:0] pc;        // next address to fetch
  logic [31:0] gnt_addr;  // address of the request currently in flight
  logic        discard;   // in-flight response belongs to a flushed path
  logic        skid_vld;
  fetch_ent_t  skid_dat;

  logic        redirect;
  logic [31:0] redir_pc;
  logic [31:0] pc_seq;

  // Redirect selection: TRAP outranks MRET, which outranks BR_TAKEN; targets are word aligned.
  always_comb begin
    redirect = TRAP | MRET | BR_TAKEN;
    if (TRAP) begin
      redir_pc = MTVEC & ALIGN_MASK;
    end else if (MRET) begin
      redir_pc = MEPC & ALIGN_MASK;
    end else begin
      redir_pc = BR_TARGET & ALIGN_MASK;
    end
  end

  // Sequential successor wraps naturally from 0xFFFF_FFFC to 0.
  assign pc_seq   = pc + 32'd4;
  assign FLUSH_IF = redirect;

  // Fetch FSM; IMEM_* and IF_* are all registered here so no IMEM input reaches an IMEM output.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_BOOT;
      pc        <= RST_PC;
      gnt_addr  <= '0;
      discard   <= 1'b0;
      skid_vld  <= 1'b0;
      skid_dat  <= '0;
      IMEM_REQ  <= 1'b0;
      IMEM_ADDR <= RST_PC;
      IF_VALID  <= 1'b0;
      IF_INSTR  <= '0;
      IF_PC     <= '0;
    end else begin
      case (state)
        // First cycle out of reset: redirects are ignored, the reset vector is always fetched first.
        ST_BOOT: begin
          state     <= ST_REQ;
          IMEM_REQ  <= 1'b1;
          IMEM_ADDR <= pc;
        end

        // Request outstanding on the bus; address held until granted or abandoned by a redirect.
        ST_REQ: begin
          if (redirect) begin
            pc        <= redir_pc;
            IF_VALID  <= 1'b0;
            skid_vld  <= 1'b0;
            IMEM_ADDR <= redir_pc;
            if (IMEM_GNT) begin
              // The granted fetch will still answer; mark it so its data is thrown away.
              state    <= ST_WAIT;
              gnt_addr <= pc;
              discard  <= 1'b1;
              IMEM_REQ <= 1'b0;
            end else begin
              IMEM_REQ <= 1'b1;
            end
          end else begin
            if (!STALL) begin
              IF_VALID <= 1'b0;
            end
            if (IMEM_GNT) begin
              state     <= ST_WAIT;
              gnt_addr  <= pc;
              pc        <= pc_seq;
              IMEM_REQ  <= 1'b0;
              IMEM_ADDR <= pc_seq;
            end
          end
        end

        // Waiting for read data of the granted request.
        ST_WAIT: begin
          if (redirect) begin
            pc        <= redir_pc;
            IF_VALID  <= 1'b0;
            skid_vld  <= 1'b0;
            IMEM_ADDR <= redir_pc;
            if (IMEM_RVALID) begin
              state    <= ST_REQ;
              discard  <= 1'b0;
              IMEM_REQ <= 1'b1;
            end else begin
              discard  <= 1'b1;
            end
          end else if (IMEM_RVALID && discard) begin
            // Stale response from a flushed path: drop it and restart at the new PC.
            state     <= ST_REQ;
            discard   <= 1'b0;
            IMEM_REQ  <= 1'b1;
            IMEM_ADDR <= pc;
            if (!STALL) begin
              IF_VALID <= 1'b0;
            end
          end else if (IMEM_RVALID) begin
            if (!IF_VALID || !STALL) begin
              IF_VALID  <= 1'b1;
              IF_INSTR  <= IMEM_RDATA;
              IF_PC     <= gnt_addr;
              state     <= ST_REQ;
              IMEM_REQ  <= 1'b1;
              IMEM_ADDR <= pc;
            end else begin
              // Decode is stalled on a valid word: park the new one and stop fetching.
              skid_vld       <= 1'b1;
              skid_dat.instr <= IMEM_RDATA;
              skid_dat.pc    <= gnt_addr;
              state          <= ST_HOLD;
            end
          end else begin
            if (!STALL) begin
              IF_VALID <= 1'b0;
            end
          end
        end

        // Skid full; nothing in flight. Resume once decode drains the IF reg.
        ST_HOLD: begin
          if (redirect) begin
            pc        <= redir_pc;
            IF_VALID  <= 1'b0;
            skid_vld  <= 1'b0;
            state     <= ST_REQ;
            IMEM_REQ  <= 1'b1;
            IMEM_ADDR <= redir_pc;
          end else if (!STALL) begin
            IF_VALID  <= skid_vld;
            IF_INSTR  <= skid_dat.instr;
            IF_PC     <= skid_dat.pc;
            skid_vld  <= 1'b0;
            state     <= ST_REQ;
            IMEM_REQ  <= 1'b1;
            IMEM_ADDR <= pc;
          end
        end

        default: begin
          state    <= ST_BOOT;
          IMEM_REQ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: random memory timing, stalls and redirects checked against a stream-level model.
// Latency: model tracks fetch/issue addresses, buffered word count and in-flight response per cycle.
// Backpressure: STALL is driven directly; the model bounds buffered words at two (IF reg + skid).
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        CLK;
  logic        RST_N;
  logic        STALL;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic        TRAP;
  logic [31:0] MTVEC;
  logic        MRET;
  logic [31:0] MEPC;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;
  logic        IF_VALID;
  logic [31:0] IF_INSTR;
  logic [31:0] IF_PC;
  logic        FLUSH_IF;

  pc_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .STALL      (STALL),
    .BR_TAKEN   (BR_TAKEN),
    .BR_TARGET  (BR_TARGET),
    .TRAP       (TRAP),
    .MTVEC      (MTVEC),
    .MRET       (MRET),
    .MEPC       (MEPC),
    .IMEM_REQ   (IMEM_REQ),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_GNT   (IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID),
    .IMEM_RDATA (IMEM_RDATA),
    .IF_VALID   (IF_VALID),
    .IF_INSTR   (IF_INSTR),
    .IF_PC      (IF_PC),
    .FLUSH_IF   (FLUSH_IF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: stream positions, words held by the fetch stage, the memory's in-flight request.
  logic [31:0] exp_fetch;
  logic [31:0] exp_if_pc;
  int          buffered;
  bit          outstanding;
  bit          out_stale;
  logic [31:0] out_addr;
  int          lat;
  bit          req_due;
  bit          in_boot;
  bit          rel_pending;

  // Stimulus knobs.
  int          gnt_mode;    // 0 never, 1 always, 2 random
  int          stall_mode;  // 0 off, 1 held, 2 random
  int          lat_min;
  int          lat_max;
  bit          rand_redir;
  bit          pend;
  int          pend_cond;   // 0 any, 1 WAIT w/o RVALID, 2 REQ w/o GNT, 3 IF_VALID (with STALL)
  logic [2:0]  pend_kind;   // {TRAP, MRET, BR_TAKEN}
  logic [31:0] p_mtvec;
  logic [31:0] p_mepc;
  logic [31:0] p_br;
  bit          reached;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_C3C3) + {a[15:0], a[31:16]} + 32'd1;
  endfunction

  function automatic logic [31:0] redir_tgt();
    logic [31:0] t;
    if (TRAP) t = MTVEC;
    else if (MRET) t = MEPC;
    else t = BR_TARGET;
    return t & 32'hFFFF_FFFC;
  endfunction

  task automatic model_reset();
    exp_fetch   = RV;
    exp_if_pc   = RV;
    buffered    = 0;
    outstanding = 1'b0;
    out_stale   = 1'b0;
    out_addr    = '0;
    lat         = 0;
    req_due     = 1'b0;
    pend        = 1'b0;
  endtask

  task automatic zero_inputs();
    STALL = 1'b0; BR_TAKEN = 1'b0; TRAP = 1'b0; MRET = 1'b0;
    BR_TARGET = '0; MTVEC = '0; MEPC = '0;
    IMEM_GNT = 1'b0; IMEM_RVALID = 1'b0; IMEM_RDATA = '0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_req"},   32'(IMEM_REQ),  32'd0);
    check_val({pfx, "_addr"},  IMEM_ADDR,      RV);
    check_val({pfx, "_ifv"},   32'(IF_VALID),  32'd0);
    check_val({pfx, "_instr"}, IF_INSTR,       32'd0);
    check_val({pfx, "_ifpc"},  IF_PC,          32'd0);
  endtask

  // Drive one cycle of inputs from the memory model and knobs (called just after the rising edge).
  task automatic drive_inputs();
    bit rv, g, ok;
    logic [2:0] k;
    rv = 1'b0;
    if (outstanding) begin
      if (lat == 0) rv = 1'b1;
      else lat--;
    end
    IMEM_RVALID = rv;
    IMEM_RDATA  = rv ? mem_word(out_addr) : $urandom;
    case (gnt_mode)
      0:       g = 1'b0;
      1:       g = 1'b1;
      default: g = ($urandom_range(1, 0) == 1);
    endcase
    IMEM_GNT = IMEM_REQ && g;
    case (stall_mode)
      1:       STALL = 1'b1;
      2:       STALL = ($urandom_range(3, 0) == 0);
      default: STALL = 1'b0;
    endcase
    TRAP = 1'b0; MRET = 1'b0; BR_TAKEN = 1'b0;
    BR_TARGET = $urandom; MTVEC = $urandom; MEPC = $urandom;
    if (pend) begin
      case (pend_cond)
        1:       ok = outstanding && !rv;
        2:       ok = IMEM_REQ && !IMEM_GNT;
        3:       ok = IF_VALID;
        default: ok = 1'b1;
      endcase
      if (ok) begin
        {TRAP, MRET, BR_TAKEN} = pend_kind;
        MTVEC = p_mtvec; MEPC = p_mepc; BR_TARGET = p_br;
        if (pend_cond == 3) STALL = 1'b1;
        pend = 1'b0;
      end
    end else if (rand_redir && $urandom_range(15, 0) == 0) begin
      k = 3'($urandom_range(7, 1));
      {TRAP, MRET, BR_TAKEN} = k;
    end
  endtask

  // Compare DUT against the model for the current cycle, then advance the model past the coming edge.
  task automatic observe();
    bit redir;
    logic [31:0] tgt;
    redir = TRAP | MRET | BR_TAKEN;
    tgt   = redir_tgt();
    check_val("flush_if", 32'(FLUSH_IF), 32'(redir));
    if (in_boot) begin
      check_val("boot_req", 32'(IMEM_REQ), 32'd0);
      check_val("boot_ifv", 32'(IF_VALID), 32'd0);
    end
    if (req_due) begin
      check_val("redir_req_next", 32'(IMEM_REQ), 32'd1);
      req_due = 1'b0;
    end
    check_val("if_valid", 32'(IF_VALID), 32'(buffered > 0));
    if (outstanding) check_val("one_outstanding", 32'(IMEM_REQ), 32'd0);
    if (buffered >= 2) check_val("skid_full_noreq", 32'(IMEM_REQ), 32'd0);
    if (IMEM_REQ) check_val("imem_addr", IMEM_ADDR, exp_fetch);
    if (IF_VALID) begin
      check_val("if_pc", IF_PC, exp_if_pc);
      check_val("if_instr", IF_INSTR, mem_word(exp_if_pc));
    end
    if (IF_VALID && (!STALL || redir)) begin
      exp_if_pc = exp_if_pc + 32'd4;
      buffered--;
    end
    if (IMEM_RVALID && outstanding) begin
      if (!out_stale && !redir) buffered++;
      outstanding = 1'b0;
    end
    if (IMEM_REQ && IMEM_GNT) begin
      outstanding = 1'b1;
      out_stale   = 1'b0;
      out_addr    = IMEM_ADDR;
      lat         = int'($urandom_range(lat_max, lat_min));
      exp_fetch   = exp_fetch + 32'd4;
    end
    if (redir && !in_boot) begin
      exp_fetch = tgt;
      exp_if_pc = tgt;
      buffered  = 0;
      if (outstanding) out_stale = 1'b1;
      else req_due = 1'b1;
    end
  endtask

  task automatic do_cycle();
    @(posedge CLK);
    #1;
    in_boot = 1'b0;
    if (rel_pending) begin
      RST_N       = 1'b1;
      rel_pending = 1'b0;
      in_boot     = 1'b1;
    end
    if (RST_N) drive_inputs();
    else zero_inputs();
    @(negedge CLK);
    if (RST_N) observe();
    else check_reset_outputs("rst");
  endtask

  task automatic set_pend(input logic [2:0] kind, input logic [31:0] mt, input logic [31:0] me,
                          input logic [31:0] br, input int cond);
    pend_kind = kind; p_mtvec = mt; p_mepc = me; p_br = br; pend_cond = cond; pend = 1'b1;
  endtask

  task automatic wait_pend(input int max);
    for (int i = 0; i < max && pend; i++) do_cycle();
    check_val("redirect_applied", 32'(pend), 32'd0);
    pend = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0;
    zero_inputs();
    model_reset();
    gnt_mode = 1; stall_mode = 0; lat_min = 0; lat_max = 0; rand_redir = 1'b0;
    rel_pending = 1'b0; in_boot = 1'b0; pend_cond = 0; pend_kind = '0;
    p_mtvec = '0; p_mepc = '0; p_br = '0; reached = 1'b0;

    // Reset, then zero-wait streaming from the reset vector.
    repeat (2) do_cycle();
    rel_pending = 1'b1;
    repeat (14) do_cycle();

    // STALL held six cycles mid-stream, then released.
    stall_mode = 1; repeat (6) do_cycle();
    stall_mode = 0; repeat (10) do_cycle();

    // Branch to 0x2003 during WAIT; its late response must be dropped.
    lat_min = 3; lat_max = 3; repeat (6) do_cycle();
    set_pend(3'b001, 32'h0, 32'h0, 32'h0000_2003, 1); wait_pend(40);
    lat_min = 0; lat_max = 0; repeat (14) do_cycle();

    // TRAP, MRET and BR_TAKEN together: trap vector wins. Then TRAP under STALL.
    set_pend(3'b111, 32'h0000_0080, 32'h0000_0900, 32'h0000_0A00, 0); wait_pend(10);
    repeat (8) do_cycle();
    set_pend(3'b100, 32'h0000_1000, 32'h0, 32'h0, 3); wait_pend(40);
    repeat (8) do_cycle();

    // Ungranted request at 0x40 abandoned by a branch to 0x300.
    gnt_mode = 0;
    set_pend(3'b001, 32'h0, 32'h0, 32'h0000_0040, 0); wait_pend(10);
    repeat (5) do_cycle();
    set_pend(3'b001, 32'h0, 32'h0, 32'h0000_0300, 2); wait_pend(20);
    gnt_mode = 1; repeat (10) do_cycle();

    // Address wrap past 0xFFFF_FFFC.
    set_pend(3'b001, 32'h0, 32'h0, 32'hFFFF_FFF8, 0); wait_pend(10);
    repeat (12) do_cycle();

    // Randomised memory timing, stalls and redirects.
    gnt_mode = 2; stall_mode = 2; rand_redir = 1'b1; lat_min = 0; lat_max = 3;
    repeat (3000) do_cycle();
    rand_redir = 1'b0; stall_mode = 0; gnt_mode = 1; lat_min = 5; lat_max = 5;
    repeat (12) do_cycle();

    // Asynchronous reset while waiting on the fetch of 0xFFFF_FFFC.
    set_pend(3'b001, 32'h0, 32'h0, 32'hFFFF_FFFC, 0); wait_pend(10);
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      do_cycle();
      if (outstanding && out_addr == 32'hFFFF_FFFC) reached = 1'b1;
    end
    check_val("reach_wait_fffc", 32'(reached), 32'd1);
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    lat_min = 0; lat_max = 1;
    repeat (2) do_cycle();
    // Redirect during BOOT is ignored; fetch restarts at the reset vector.
    rel_pending = 1'b1;
    set_pend(3'b001, 32'h0, 32'h0, 32'h0000_0700, 0);
    do_cycle();
    check_val("boot_redir_taken", 32'(pend), 32'd0);
    repeat (16) do_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-stage sequencer that owns the program counter and drives the instruction-memory request handshake for the pipelined RV32 core. Each cycle it selects the next PC: sequential, branch/jump, trap vector or MRET return. It issues one outstanding fetch at a time and presents fetched instructions to decode with stall and flush support. It replaces direct PC_IN muxing at the top level.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- STALL  in  1  decode cannot accept; hold IF outputs
- BR_TAKEN  in  1  branch/jump redirect from EX
- BR_TARGET  in  32  redirect target; bits [1:0] forced to 0
- TRAP  in  1  trap redirect
- MTVEC  in  32  trap target; bits [1:0] forced to 0
- MRET  in  1  return redirect
- MEPC  in  32  return target; bits [1:0] forced to 0
- IMEM_REQ  out  1  fetch request valid
- IMEM_ADDR  out  32  fetch address
- IMEM_GNT  in  1  address accepted this cycle
- IMEM_RVALID  in  1  read data valid; at most one per granted request, ≥1 cycle after GNT
- IMEM_RDATA  in  32  instruction word
- IF_VALID  out  1  IF_INSTR/IF_PC valid
- IF_INSTR  out  32  fetched instruction
- IF_PC  out  32  address of IF_INSTR
- FLUSH_IF  out  1  combinational; equals redirect (TRAP|MRET|BR_TAKEN)

## Operation
- States: BOOT, REQ, WAIT, HOLD. The PC register holds the address to fetch next. A one-entry skid buffer (valid, instr, pc) backs the IF output register.
- Reset (RST_N low, any time, asynchronous): state=BOOT, pc=RESET_VECTOR, IMEM_REQ=0, IMEM_ADDR=RESET_VECTOR, IF_VALID=0, IF_INSTR=0, IF_PC=0, skid empty, discard=0.
- BOOT: unconditionally moves to REQ on the first edge after RST_N rises.
- REQ: IMEM_REQ=1, IMEM_ADDR=pc, held stable until GNT. On GNT: go to WAIT, record the granted address, pc<=pc+4 (wraps 0xFFFF_FFFC→0).
- WAIT: IMEM_REQ=0. On RVALID with discard=0:
  - If the IF reg is empty or STALL=0, load it (IF_VALID=1, IF_PC=granted address) and go to REQ.
  - Otherwise, load the skid buffer and go to HOLD.
- HOLD: IMEM_REQ=0. When STALL=0, skid moves to the IF reg, skid empties, go to REQ.
- IF reg consumption: when STALL=0 and no new data arrives, IF_VALID<=0. When STALL=1, IF_VALID/IF_INSTR/IF_PC hold unchanged.
- Redirect priority: TRAP > MRET > BR_TAKEN. Target = MTVEC / MEPC / BR_TARGET with [1:0]=0. A redirect overrides STALL.
- On a redirect in any state except BOOT:
  - pc<=target, IF_VALID<=0, skid cleared.
  - REQ without GNT: stay in REQ; IMEM_ADDR=target next cycle. The ungranted request is abandoned.
  - REQ with GNT same cycle: go to WAIT with discard=1; pc<=target, no +4.
  - WAIT without RVALID: stay in WAIT, discard=1.
  - WAIT with RVALID same cycle: drop the data and go to REQ.
  - HOLD: go to REQ.
- Discarded response: in WAIT with discard=1, RVALID drops the data, clears discard and goes to REQ. IF outputs are unaffected.
- Redirect in BOOT: target is ignored; RESET_VECTOR is fetched.

## Timing
- Redirect asserted in cycle N: FLUSH_IF=1 in N. IMEM_ADDR=target with IMEM_REQ=1 in N+1, or later if a discarded response is still pending.
- Zero-wait memory (GNT in REQ cycle, RVALID the next cycle): REQ at c, IF_VALID at c+2. Steady-state throughput is one instruction per 2 cycles.
- Only one request is outstanding at any time. No new REQ is issued while the skid buffer is full.
- All outputs except FLUSH_IF are registered. There is no combinational path from IMEM_* inputs to IMEM_* outputs.

## Test plan
- Reset release, RESET_VECTOR=0x100, GNT always 1, RVALID one cycle later: IF_PC sequence 0x100, 0x104, 0x108. IF_VALID every other cycle; IF_INSTR matches RDATA.
- STALL held 6 cycles during streaming: IF outputs hold, skid captures one word, IMEM_REQ stays 0. On release, instructions appear in order with none lost or duplicated.
- BR_TAKEN, BR_TARGET=0x2003, in a WAIT cycle with RVALID three cycles later: FLUSH_IF=1 for that cycle and the late data is dropped. The next IMEM_ADDR is 0x2000, and IF_PC=0x2000 is the next valid output.
- TRAP, MRET and BR_TAKEN in the same cycle, MTVEC=0x80: next fetch is 0x80. TRAP+STALL: redirect still taken and IF_VALID=0.
- GNT held low 4 cycles at 0x40, then BR_TAKEN to 0x300: IMEM_ADDR stable at 0x40 while ungranted, 0x300 the following cycle. No response is expected for 0x40.
- RST_N pulsed low mid-WAIT with PC at 0xFFFF_FFFC: outputs reset immediately and asynchronously, and fetch restarts at RESET_VECTOR. A separate run shows 0xFFFF_FFFC followed by 0x0 wrap.
